multicycle_ctrl: RTL

//  Multi-cycle sequencer for the RV32I core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with illegal-opcode and memory-timeout traps.
// Datapath controls are decoded from the current state, the opcode and the ready/compare flags.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic [1:0]       alu_op,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Counter only has to reach TIMEOUT_CYC-1: the next low cycle is the trap decision.
    localparam int              WAIT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT_CYC > 0) ? WAIT_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit              TMO_EN    = (TIMEOUT_CYC > 0);

    logic [2:0]        r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_cause;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        w_next;
    logic              w_legal;
    logic              w_tmo;
    logic              w_waiting;
    logic              w_unused;

    // funct3 is consumed by the ALU itself when alu_op selects funct3/funct7 decode.
    assign w_unused = ^funct3;

    assign w_legal = (opcode == OP_R)      || (opcode == OP_I)    || (opcode == OP_LOAD) ||
                     (opcode == OP_STORE)  || (opcode == OP_BRANCH) || (opcode == OP_JAL) ||
                     (opcode == OP_JALR)   || (opcode == OP_LUI)  || (opcode == OP_AUIPC);
    assign w_tmo     = TMO_EN && (r_wait == WAIT_LAST);
    assign w_waiting = ((r_state == S_FETCH) && !imem_ready) || ((r_state == S_MEM) && !dmem_ready);

    always_comb begin
        w_next    = r_state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        alu_op    = 2'd0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_tmo) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                w_next = S_WB;
                case (opcode)
                    OP_R:     alu_op = 2'd1;
                    OP_I: begin
                        alu_op    = 2'd1;
                        alu_b_sel = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel = 1'b1;
                        w_next    = S_MEM;
                    end
                    OP_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    OP_BRANCH: begin
                        alu_op = 2'd2;
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? 2'd1 : 2'd0;
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_tmo) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                w_next = S_FETCH;
                case (opcode)
                    OP_LOAD: wb_sel = 2'd1;
                    OP_JAL: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd1;
                    end
                    OP_JALR: begin
                        wb_sel = 2'd2;
                        pc_sel = 2'd2;
                    end
                    OP_LUI:  wb_sel = 2'd3;
                    default: ;
                endcase
            end
            S_TRAP:  ;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_cause <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Any state change restarts the wait window, so entry to FETCH/MEM always starts at zero.
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_waiting && TMO_EN)
                r_wait <= r_wait + 1'b1;
            if (w_next == S_TRAP && r_state != S_TRAP) begin
                case (r_state)
                    S_DECODE: r_cause <= 2'd1;
                    S_FETCH:  r_cause <= 2'd2;
                    S_MEM:    r_cause <= 2'd3;
                    default:  r_cause <= r_cause;
                endcase
            end
            if (retire)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign trap       = (r_state == S_TRAP);
    assign trap_cause = r_cause;
    assign retire_cnt = r_cnt;
    assign state      = r_state;

endmodule
